// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Optional grant statistics counters are enabled with the ALU_SCHED_STATS_EN macro.
module alu_rr_scheduler #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [4:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [4:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_a_or_l,
   output logic             alu_s_or_u,
   output logic [2:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
`endif
);

   // state | meaning
   // IDLE  | arbitrating; ready pulses to the winner
   // EXEC  | ALU inputs held stable for ALU_LAT cycles
   // RESP  | result presented until rsp_ready
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t     state_q;
   state_t     state_d;
   logic       ptr_q;
   logic [3:0] cnt_q;
   logic       grant0;
   logic       grant1;

   // Gating with reset keeps ready low during the reset cycle itself.
   assign grant0 = (state_q == IDLE) && !reset && req0_valid && (!req1_valid || !ptr_q);
   assign grant1 = (state_q == IDLE) && !reset && req1_valid && (!req0_valid || ptr_q);

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant0 || grant1) state_d = EXEC;
         EXEC:    if (cnt_q == 4'd0)    state_d = RESP;
         RESP:    if (rsp_ready)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= 1'b0;
         cnt_q      <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_a_or_l <= 1'b0;
         alu_s_or_u <= 1'b0;
         alu_opcode <= 3'd0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0) begin
                  alu_a      <= req0_a;
                  alu_b      <= req0_b;
                  alu_a_or_l <= req0_ctrl[4];
                  alu_s_or_u <= req0_ctrl[3];
                  alu_opcode <= req0_ctrl[2:0];
                  rsp_id     <= 1'b0;
                  cnt_q      <= CNT_INIT;
               end else if (grant1) begin
                  alu_a      <= req1_a;
                  alu_b      <= req1_b;
                  alu_a_or_l <= req1_ctrl[4];
                  alu_s_or_u <= req1_ctrl[3];
                  alu_opcode <= req1_ctrl[2:0];
                  rsp_id     <= 1'b1;
                  cnt_q      <= CNT_INIT;
               end
            end
            EXEC: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_data  <= alu_result;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr_q     <= ~rsp_id;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule
